// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO interconnect.
// Holds the data width, the access size encodings, the FSM state enum and the
// registered slave-side request payload.
package mmio_pkg;

  localparam int unsigned MMIO_DW = 32;
  localparam int unsigned MMIO_BW = MMIO_DW / 8;

  // m_size[1:0] encodings; m_size[2] selects zero extension on reads
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Slave-side request, registered at acceptance and held through ACCESS
  typedef struct packed {
    logic               we;
    logic [MMIO_DW-1:0] addr;
    logic [MMIO_BW-1:0] be;
    logic [MMIO_DW-1:0] wdata;
  } slv_req_t;

endpackage

// File: rtl/mmio_interconnect_if.sv
// Bus bundle between the core data port, the interconnect and N slaves.
// Modports:
//   master - the bus environment (core drives m_req..m_wdata, peripherals drive
//            s_rdata/s_ready)
//   slave  - the interconnect (answers the core, drives the slave select/strobes)
interface mmio_interconnect_if #(
  parameter int unsigned N_SLAVES = 4
) ();
  import mmio_pkg::*;

  logic                          m_req;
  logic                          m_we;
  logic [MMIO_DW-1:0]            m_addr;
  logic [2:0]                    m_size;
  logic [MMIO_DW-1:0]            m_wdata;
  logic                          m_ready;
  logic                          m_err;
  logic [MMIO_DW-1:0]            m_rdata;

  logic [N_SLAVES-1:0]           s_sel;
  logic                          s_we;
  logic [MMIO_DW-1:0]            s_addr;
  logic [MMIO_BW-1:0]            s_be;
  logic [MMIO_DW-1:0]            s_wdata;
  logic [N_SLAVES*MMIO_DW-1:0]   s_rdata;
  logic [N_SLAVES-1:0]           s_ready;

  modport master (
    output m_req, m_we, m_addr, m_size, m_wdata, s_rdata, s_ready,
    input  m_ready, m_err, m_rdata, s_sel, s_we, s_addr, s_be, s_wdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_size, m_wdata, s_rdata, s_ready,
    output m_ready, m_err, m_rdata, s_sel, s_we, s_addr, s_be, s_wdata
  );

endinterface

// File: rtl/mmio_lane_align.sv
// Combinational byte-lane steering.
// Inputs : addr_lo (byte offset), size ({unsigned, size[1:0]}), wdata
//          (right-aligned write data), rdata (raw slave word).
// Outputs: be_c (byte enables), wdata_c (lane-replicated write data),
//          rdata_c (selected lane shifted down and sign/zero extended).
module mmio_lane_align
  import mmio_pkg::*;
(
  input  logic [1:0]         addr_lo,
  input  logic [2:0]         size,
  input  logic [MMIO_DW-1:0] wdata,
  input  logic [MMIO_DW-1:0] rdata,
  output logic [MMIO_BW-1:0] be_c,
  output logic [MMIO_DW-1:0] wdata_c,
  output logic [MMIO_DW-1:0] rdata_c
);

  logic [MMIO_DW-1:0] shifted;
  logic               zext;

  // Lane selection and extension; illegal size yields all zeros
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    zext    = size[2];
    be_c    = '0;
    wdata_c = '0;
    rdata_c = '0;
    unique case (size[1:0])
      SZ_BYTE: begin
        be_c    = 4'b0001 << addr_lo;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = {{24{shifted[7] & ~zext}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
        rdata_c = {{16{shifted[15] & ~zext}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        rdata_c = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mmio_interconnect.sv
// Memory-mapped interconnect between the core data port and N_SLAVES slaves.
// Base/mask decode (lowest index wins), byte/half/word lane steering, per-slave
// ready handshake, bus error on unmapped/misaligned/illegal-size accesses.
// Ports: clk, reset_n (async, active-low), bus (mmio_interconnect_if.slave).
// Build option: define MMIO_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int unsigned                 N_SLAVES       = 4,
  parameter logic [N_SLAVES*MMIO_DW-1:0] SLV_BASE       = {32'h0000_3000, 32'h0000_2000,
                                                           32'h0000_1000, 32'h0000_0000},
  parameter logic [N_SLAVES*MMIO_DW-1:0] SLV_MASK       = {4{32'hFFFF_F000}},
  parameter int unsigned                 TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                reset_n,
  mmio_interconnect_if.slave bus
);

  state_e              state_q, state_d;
  slv_req_t            req_q, req_d;
  logic [N_SLAVES-1:0] s_sel_q, s_sel_d;
  logic [1:0]          lo_q, lo_d;
  logic [2:0]          size_q, size_d;
  logic                m_ready_q, m_ready_d;
  logic                m_err_q, m_err_d;
  logic [MMIO_DW-1:0]  m_rdata_q, m_rdata_d;

  logic                hit, bad_align, dec_err, sel_ready, end_access;
  logic [N_SLAVES-1:0] hit_oh;
  logic [MMIO_DW-1:0]  hit_off, sel_rdata;
  logic [MMIO_BW-1:0]  be_c;
  logic [MMIO_DW-1:0]  wdata_c, rdata_c;

`ifdef MMIO_TIMEOUT_EN
  logic [15:0]         cnt_q, cnt_d;
`else
  logic [15:0]         timeout_cfg_unused;
  assign timeout_cfg_unused = 16'(TIMEOUT_CYCLES);
`endif

  // Address decode: first matching slave in index order
  always_comb begin
    hit     = 1'b0;
    hit_oh  = '0;
    hit_off = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (!hit && ((bus.m_addr & SLV_MASK[i*MMIO_DW +: MMIO_DW]) == SLV_BASE[i*MMIO_DW +: MMIO_DW])) begin
        hit       = 1'b1;
        hit_oh[i] = 1'b1;
        hit_off   = bus.m_addr & ~SLV_MASK[i*MMIO_DW +: MMIO_DW];
      end
    end
  end

  // Alignment / legal-size check
  always_comb begin
    unique case (bus.m_size[1:0])
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = bus.m_addr[0];
      SZ_WORD: bad_align = |bus.m_addr[1:0];
      default: bad_align = 1'b1;
    endcase
    dec_err = !hit || bad_align;
  end

  // Ready and read data of the selected slave only
  always_comb begin
    sel_ready = |(bus.s_ready & s_sel_q);
    sel_rdata = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (s_sel_q[i]) sel_rdata = bus.s_rdata[i*MMIO_DW +: MMIO_DW];
    end
  end

  // Shared lane logic: request fields while IDLE, registered fields afterwards
  mmio_lane_align u_lane_align (
    .addr_lo (state_q == ST_IDLE ? bus.m_addr[1:0] : lo_q),
    .size    (state_q == ST_IDLE ? bus.m_size : size_q),
    .wdata   (bus.m_wdata),
    .rdata   (sel_rdata),
    .be_c    (be_c),
    .wdata_c (wdata_c),
    .rdata_c (rdata_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    s_sel_d    = s_sel_q;
    lo_d       = lo_q;
    size_d     = size_q;
    m_ready_d  = 1'b0;
    m_err_d    = 1'b0;
    m_rdata_d  = '0;
    end_access = 1'b0;
`ifdef MMIO_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.m_req) begin
          lo_d   = bus.m_addr[1:0];
          size_d = bus.m_size;
          if (dec_err) begin
            state_d   = ST_RESP;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            s_sel_d     = hit_oh;
            req_d.we    = bus.m_we;
            req_d.addr  = hit_off & ~MMIO_DW'(3);
            req_d.be    = be_c;
            req_d.wdata = wdata_c;
`ifdef MMIO_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_d    = ST_RESP;
          m_ready_d  = 1'b1;
          m_rdata_d  = req_q.we ? '0 : rdata_c;
          end_access = 1'b1;
`ifdef MMIO_TIMEOUT_EN
        end else if (cnt_q == 16'(TIMEOUT_CYCLES)) begin
          state_d    = ST_RESP;
          m_ready_d  = 1'b1;
          m_err_d    = 1'b1;
          end_access = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Slave side returns to zero as soon as the access completes
    if (end_access) begin
      s_sel_d = '0;
      req_d   = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      s_sel_q   <= '0;
      lo_q      <= '0;
      size_q    <= '0;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
`ifdef MMIO_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      s_sel_q   <= s_sel_d;
      lo_q      <= lo_d;
      size_q    <= size_d;
      m_ready_q <= m_ready_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
`ifdef MMIO_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.m_ready = m_ready_q;
  assign bus.m_err   = m_err_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.s_sel   = s_sel_q;
  assign bus.s_we    = req_q.we;
  assign bus.s_addr  = req_q.addr;
  assign bus.s_be    = req_q.be;
  assign bus.s_wdata = req_q.wdata;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Scoreboard bench for mmio_interconnect: directed requests push expected
// master responses and slave accesses; monitors pop and compare.
module tb_mmio_interconnect;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } mexp_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } sexp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  mexp_t       mq[$];
  sexp_t       sq[$];

  mmio_interconnect_if #(.N_SLAVES(4)) bus ();

  mmio_interconnect #(.N_SLAVES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Master-side monitor
  initial begin
    mexp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.m_ready) begin
        if (mq.size() == 0) begin
          chk("unexpected_m_ready", 64'(bus.m_ready), 64'd0);
        end else begin
          e = mq.pop_front();
          chk("m_err", 64'(bus.m_err), 64'(e.err));
          chk("m_rdata", 64'(bus.m_rdata), 64'(e.rdata));
          chk("m_ready_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Slave model and slave-side monitor
  initial begin
    int unsigned cnt;
    logic [3:0]  prev;
    sexp_t       e;
    cnt = 0;
    prev = '0;
    bus.s_ready = '0;
    bus.s_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.s_sel != 4'b0) begin
        if (prev == 4'b0) begin
          cnt = 0;
          if (sq.size() == 0) begin
            chk("unexpected_s_sel", 64'(bus.s_sel), 64'd0);
          end else begin
            e = sq.pop_front();
            chk("s_sel", 64'(bus.s_sel), 64'(e.sel));
            chk("s_we", 64'(bus.s_we), 64'(e.we));
            chk("s_addr", 64'(bus.s_addr), 64'(e.addr));
            chk("s_be", 64'(bus.s_be), 64'(e.be));
            chk("s_wdata", 64'(bus.s_wdata), 64'(e.wdata));
          end
        end else begin
          cnt++;
        end
        for (int i = 0; i < 4; i++)
          bus.s_rdata[i*32 +: 32] = bus.s_sel[i] ? slv_rdata : ~slv_rdata;
        bus.s_ready = (cnt == slv_wait) ? bus.s_sel : 4'b0;
      end else begin
        bus.s_ready = '0;
      end
      prev = bus.s_sel;
    end
  end

  // One request: push expectations, pulse m_req, wait for both queues to drain
  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input int unsigned wt, input logic [31:0] srd,
                       input logic eerr, input logic [31:0] erd, input int unsigned lat,
                       input logic [3:0] esel, input logic [31:0] eaddr,
                       input logic [3:0] ebe, input logic [31:0] ewd);
    @(negedge clk);
    slv_wait    = wt;
    slv_rdata   = srd;
    bus.m_req   = 1'b1;
    bus.m_we    = we;
    bus.m_addr  = addr;
    bus.m_size  = size;
    bus.m_wdata = wdata;
    mq.push_back('{err: eerr, rdata: erd, cyc: 32'(cyc + lat)});
    if (esel != 4'b0) sq.push_back('{sel: esel, we: we, addr: eaddr, be: ebe, wdata: ewd});
    @(negedge clk);
    bus.m_req = 1'b0;
    for (int n = 0; n < 100 && (mq.size() != 0 || sq.size() != 0); n++) @(negedge clk);
    chk("drain_master", 64'(mq.size()), 64'd0);
    chk("drain_slave", 64'(sq.size()), 64'd0);
    mq.delete();
    sq.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    bus.m_req   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_size  = '0;
    bus.m_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_m", 64'({bus.m_ready, bus.m_err, bus.m_rdata}), 64'd0);
    chk("rst_s_sel", 64'(bus.s_sel), 64'd0);
    chk("rst_s_ctl", 64'({bus.s_we, bus.s_be, bus.s_addr}), 64'd0);
    chk("rst_s_wdata", 64'(bus.s_wdata), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    //    we    addr          size    wdata         wt srd           err  erd           lat sel     saddr         be       swdata
    issue(1'b1, 32'h0000_1004, 3'b010, 32'hDEAD_BEEF, 0, 32'h0,        1'b0, 32'h0,        2, 4'b0010, 32'h4, 4'b1111, 32'hDEAD_BEEF);
    issue(1'b0, 32'h0000_2003, 3'b000, 32'h0,        3, 32'h80AA_BBCC, 1'b0, 32'hFFFF_FF80, 5, 4'b0100, 32'h0, 4'b1000, 32'h0);
    issue(1'b0, 32'h0000_2003, 3'b100, 32'h0,        3, 32'h80AA_BBCC, 1'b0, 32'h0000_0080, 5, 4'b0100, 32'h0, 4'b1000, 32'h0);
    issue(1'b0, 32'h0000_0002, 3'b001, 32'h0,        0, 32'h1234_ABCD, 1'b0, 32'h0000_1234, 2, 4'b0001, 32'h0, 4'b1100, 32'h0);
    issue(1'b1, 32'h0000_0002, 3'b001, 32'h0000_BEEF, 0, 32'h0,        1'b0, 32'h0,        2, 4'b0001, 32'h0, 4'b1100, 32'hBEEF_BEEF);
    issue(1'b0, 32'h0000_8000, 3'b010, 32'h0,        0, 32'h0,        1'b1, 32'h0,        1, 4'b0000, 32'h0, 4'b0000, 32'h0);
    issue(1'b0, 32'h0000_1002, 3'b010, 32'h0,        0, 32'h0,        1'b1, 32'h0,        1, 4'b0000, 32'h0, 4'b0000, 32'h0);
    issue(1'b0, 32'h0000_3000, 3'b011, 32'h0,        0, 32'h0,        1'b1, 32'h0,        1, 4'b0000, 32'h0, 4'b0000, 32'h0);
    issue(1'b0, 32'h0000_3001, 3'b001, 32'h0,        0, 32'h0,        1'b1, 32'h0,        1, 4'b0000, 32'h0, 4'b0000, 32'h0);
    issue(1'b0, 32'h0000_3001, 3'b000, 32'h0,        1, 32'h1122_7F44, 1'b0, 32'h0000_007F, 3, 4'b1000, 32'h0, 4'b0010, 32'h0);
    issue(1'b0, 32'h0000_3000, 3'b001, 32'h0,        0, 32'h0000_8001, 1'b0, 32'hFFFF_8001, 2, 4'b1000, 32'h0, 4'b0011, 32'h0);
    issue(1'b0, 32'h0000_300C, 3'b110, 32'h0,        2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 4, 4'b1000, 32'hC, 4'b1111, 32'h0);
    issue(1'b1, 32'h0000_0ACD, 3'b000, 32'h1234_56A5, 0, 32'h0,        1'b0, 32'h0,        2, 4'b0001, 32'hACC, 4'b0010, 32'hA5A5_A5A5);

`ifdef MMIO_TIMEOUT_EN
    issue(1'b0, 32'h0000_0000, 3'b010, 32'h0, 1000, 32'h5555_AAAA, 1'b1, 32'h0,        10, 4'b0001, 32'h0, 4'b1111, 32'h0);
    issue(1'b0, 32'h0000_0000, 3'b010, 32'h0, 8,    32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 10, 4'b0001, 32'h0, 4'b1111, 32'h0);
`endif

    // Reset while an access is stalled in ACCESS
    @(negedge clk);
    slv_wait    = 1000;
    slv_rdata   = 32'h0;
    bus.m_req   = 1'b1;
    bus.m_we    = 1'b0;
    bus.m_addr  = 32'h0000_1000;
    bus.m_size  = 3'b010;
    bus.m_wdata = 32'h0;
    sq.push_back('{sel: 4'b0010, we: 1'b0, addr: 32'h0, be: 4'b1111, wdata: 32'h0});
    @(negedge clk);
    bus.m_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_s_sel", 64'(bus.s_sel), 64'(4'b0010));
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_s_sel", 64'(bus.s_sel), 64'd0);
    chk("async_rst_m_ready", 64'(bus.m_ready), 64'd0);
    chk("async_rst_s_be", 64'(bus.s_be), 64'd0);
    chk("rst_slave_seen", 64'(sq.size()), 64'd0);
    sq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h0000_1008, 3'b010, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 3, 4'b0010, 32'h8, 4'b1111, 32'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_interconnect.md
# mmio_interconnect

Parametrised memory-mapped interconnect between the RV32 core data port and N peripheral slaves (RAM, keyboard, display, future timers/audio). It replaces the fixed single-cycle, word-only decoder with a base/mask address map, byte/halfword/word access with lane steering and sign/zero extension, and a per-slave ready handshake for wait states. Unmapped or misaligned accesses return a bus error instead of silently aliasing.

## Interface
- N_SLAVES, 4: number of slave ports, 1..8.
- SLV_BASE, {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}: packed N_SLAVES×32 base addresses; slave i in bits [32i+31:32i].
- SLV_MASK, {4{32'hFFFF_F000}}: packed N_SLAVES×32 decode masks; slave i hits when (addr & MASK_i) == BASE_i.
- TIMEOUT_CYCLES, 255: cycles in ACCESS before abort, 1..65535.

Ports:
- clk  in  1  system clock (clk_100 domain).
- reset_n  in  1  asynchronous, active-low reset.
- m_req  in  1  request; sampled only in IDLE.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  32  byte address.
- m_size  in  3  {unsigned, size[1:0]}; size 00 byte, 01 half, 10 word, 11 illegal (error).
- m_wdata  in  32  write data, right-aligned.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  valid with m_ready; 1 = unmapped, misaligned, illegal size, or timeout.
- m_rdata  out  32  extended read data, valid with m_ready (0 on writes and errors).
- s_sel  out  N_SLAVES  one-hot slave select, held through ACCESS.
- s_we  out  1  write strobe, qualified by s_sel.
- s_addr  out  32  offset = addr & ~MASK_i, word-aligned (bits [1:0] = 0).
- s_be  out  4  byte enables.
- s_wdata  out  32  lane-replicated write data.
- s_rdata  in  N_SLAVES×32  per-slave read data.
- s_ready  in  N_SLAVES  per-slave completion; sampled only for the selected slave.

## Operation
- FSM: IDLE, ACCESS, RESP.
- IDLE: on m_req, register we/addr/size/wdata; decode. Lowest matching index wins on overlap. Miss, size 11, half with addr[0]=1, or word with addr[1:0]≠0 → RESP with err=1, no s_sel. Otherwise → ACCESS.
- ACCESS: s_sel[i], s_we, s_addr, s_be, s_wdata driven from registers. On s_ready[i]=1: capture s_rdata[i] (reads), → RESP err=0.
- RESP: m_ready=1 for exactly one cycle with m_err/m_rdata; → IDLE. m_req during ACCESS/RESP is ignored; master holds nothing after acceptance.
- Lanes: byte be = 1<<addr[1:0], wdata {4{b}}; half be = addr[1]?1100:0011, wdata {2{h}}; word be 1111.
- Read extension: selected lane shifted to bit 0; sign-extended unless m_size[2]=1 (zero-extended). Word ignores m_size[2].
- Reset (any time, incl. mid-ACCESS): state IDLE, all outputs 0; slave sees s_sel drop asynchronously, in-flight access is abandoned.

## Timing
- Cycle 0 m_req accepted; cycle 1 s_sel asserted; slave ready in cycle k≥1 → m_ready in cycle k+1. Zero-wait access: m_ready 2 cycles after acceptance.
- Error on decode: m_ready/m_err in cycle 1.
- Minimum request spacing: 3 cycles (accept, ACCESS, RESP) for zero-wait slaves.
- All outputs registered; no combinational path from m_* or s_* inputs to any output.

## Configuration
- MMIO_TIMEOUT_EN defined: 16-bit counter clears on ACCESS entry, increments each ACCESS cycle; when it reaches TIMEOUT_CYCLES without s_ready → RESP with err=1, m_rdata 0. s_ready on the same cycle as expiry wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES ignored.

## Structure
- mmio_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, constant MMIO_DW=32.
- Sub-module mmio_lane_align: combinational be/wdata generation and read shift/extension; instantiated once, verified standalone.

## Test plan
- Word write 0xDEADBEEF to 0x1004, slave 1 ready immediately → s_sel=0010, s_addr=0x4, s_be=1111; m_ready 2 cycles after accept, m_err=0.
- Signed byte read 0x2003, slave 2 returns 0x80AABBCC after 3 wait cycles → s_be=1000, m_rdata=0xFFFFFF80, m_ready at accept+5; same with unsigned → 0x00000080.
- Half read 0x0002 from 0x1234ABCD → m_rdata 0x00001234; half write 0xBEEF to 0x0002 → s_be=1100, s_wdata=0xBEEFBEEF.
- Read 0x8000 (unmapped) and word read 0x1002 (misaligned) → m_ready+m_err at accept+1, s_sel never asserted.
- MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never ready → m_err at accept+10; s_ready on expiry cycle → m_err=0.
- reset_n low during ACCESS → s_sel, m_ready immediately 0; next request after release completes normally.
